// File: rtl/writeback_stage_p_if.sv
// -----------------------------------------------------------------------------
// writeback_stage_p_if
// M-stage to W-stage bus for the writeback stage of the pipelined RISC-V core.
//   valid_m_i       M-stage instruction valid
//   src_data_m_i    packed result sources, source k at [k*XLEN +: XLEN]
//                   (0 = ALU, 1 = load data, 2 = PC+4, 3+ = imm/CSR)
//   result_src_m_i  result source select
//   load_type_m_i   load funct3 (LB/LH/LW/LBU/LHU)
//   byte_off_m_i    load address bits [1:0]
//   reg_write_m_i   instruction writes rd
//   rd_m_i          destination register
// The memory stage drives through `master`; the writeback stage reads
// through `slave`.
// -----------------------------------------------------------------------------
interface writeback_stage_p_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_SRC),
    parameter int unsigned RF_AW   = 5
);
    logic                    valid_m_i;
    logic [NUM_SRC*XLEN-1:0] src_data_m_i;
    logic [SRC_W-1:0]        result_src_m_i;
    logic [2:0]              load_type_m_i;
    logic [1:0]              byte_off_m_i;
    logic                    reg_write_m_i;
    logic [RF_AW-1:0]        rd_m_i;

    modport master (
        output valid_m_i, src_data_m_i, result_src_m_i, load_type_m_i,
               byte_off_m_i, reg_write_m_i, rd_m_i
    );

    modport slave (
        input  valid_m_i, src_data_m_i, result_src_m_i, load_type_m_i,
               byte_off_m_i, reg_write_m_i, rd_m_i
    );
endinterface

// File: rtl/writeback_stage_p.sv
// -----------------------------------------------------------------------------
// writeback_stage_p
// MEM/WB pipeline register with stall/flush, result source selection, load
// data alignment/extension, register-file write qualification and a retired
// instruction counter.
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   stall_i         hold W register contents
//   flush_i         insert bubble into W (wins over stall)
//   mIf             M-stage bus (writeback_stage_p_if.slave)
//   result_w_o      final writeback value (combinational from W registers)
//   rd_w_o          destination register
//   reg_write_w_o   qualified register-file write enable (never for x0)
//   valid_w_o       W holds a valid instruction
//   retire_count_o  retired instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module writeback_stage_p #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_SRC),
    parameter int unsigned RF_AW   = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    writeback_stage_p_if.slave mIf,
    output logic [XLEN-1:0]   result_w_o,
    output logic [RF_AW-1:0]  rd_w_o,
    output logic              reg_write_w_o,
    output logic              valid_w_o,
    output logic [CNT_W-1:0]  retire_count_o
);

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    logic                    validW;
    logic                    regWriteW;
    logic [NUM_SRC*XLEN-1:0] srcW;
    logic [SRC_W-1:0]        resultSrcW;
    logic [2:0]              loadTypeW;
    logic [1:0]              byteOffW;
    logic [RF_AW-1:0]        rdW;
    logic [CNT_W-1:0]        retireCnt;

    logic [XLEN-1:0]         loadWord;
    logic [7:0]              loadByte;
    logic [15:0]             loadHalf;
    logic [XLEN-1:0]         loadExt;
    logic [XLEN-1:0]         resultMux;

    // The write enable is qualified (valid, reg_write, rd != x0) before the
    // register so reg_write_w_o is a clean flop output; flush clears it
    // together with valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validW     <= 1'b0;
            regWriteW  <= 1'b0;
            srcW       <= '0;
            resultSrcW <= '0;
            loadTypeW  <= '0;
            byteOffW   <= '0;
            rdW        <= '0;
            retireCnt  <= '0;
        end else if (flush_i) begin
            validW     <= 1'b0;
            regWriteW  <= 1'b0;
        end else if (!stall_i) begin
            validW     <= mIf.valid_m_i;
            regWriteW  <= mIf.valid_m_i & mIf.reg_write_m_i & (mIf.rd_m_i != '0);
            srcW       <= mIf.src_data_m_i;
            resultSrcW <= mIf.result_src_m_i;
            loadTypeW  <= mIf.load_type_m_i;
            byteOffW   <= mIf.byte_off_m_i;
            rdW        <= mIf.rd_m_i;
            if (mIf.valid_m_i) begin
                retireCnt <= retireCnt + CNT_W'(1);
            end
        end
    end

    // Load extraction on source 1. Misaligned halfwords use byte_off[1] only.
    always_comb begin
        loadWord = srcW[XLEN +: XLEN];
        case (byteOffW)
            2'd0:    loadByte = loadWord[7:0];
            2'd1:    loadByte = loadWord[15:8];
            2'd2:    loadByte = loadWord[23:16];
            default: loadByte = loadWord[31:24];
        endcase
        loadHalf = byteOffW[1] ? loadWord[31:16] : loadWord[15:0];
        case (loadTypeW)
            LOAD_LB:  loadExt = XLEN'($signed(loadByte));
            LOAD_LH:  loadExt = XLEN'($signed(loadHalf));
            LOAD_LW:  loadExt = XLEN'($signed(loadWord[31:0]));
            LOAD_LBU: loadExt = XLEN'(loadByte);
            LOAD_LHU: loadExt = XLEN'(loadHalf);
            default:  loadExt = loadWord;
        endcase
    end

    // Out-of-range selects match no source and fall through to zero.
    always_comb begin
        resultMux = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (resultSrcW == SRC_W'(k)) begin
                resultMux = (k == 1) ? loadExt : srcW[k*XLEN +: XLEN];
            end
        end
    end

    assign result_w_o     = resultMux;
    assign rd_w_o         = rdW;
    assign reg_write_w_o  = regWriteW;
    assign valid_w_o      = validW;
    assign retire_count_o = retireCnt;

endmodule

// File: tb/tb_writeback_stage_p.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage_p
// Directed self-checking bench for writeback_stage_p. Instance dutA is the
// default build (XLEN=32, NUM_SRC=4, CNT_W=32); dutB is a NUM_SRC=3, CNT_W=4
// build for the out-of-range select and counter wrap.
// -----------------------------------------------------------------------------
module tb_writeback_stage_p;

    logic clk = 1'b0;
    logic rst_n;
    logic stallA, flushA, stallB, flushB;

    always #5 clk = ~clk;

    writeback_stage_p_if #(.XLEN(32), .NUM_SRC(4), .RF_AW(5)) ifA ();
    writeback_stage_p_if #(.XLEN(32), .NUM_SRC(3), .RF_AW(5)) ifB ();

    logic [31:0] resultA, resultB;
    logic [4:0]  rdA, rdB;
    logic        regWriteA, regWriteB, validA, validB;
    logic [31:0] countA;
    logic [3:0]  countB;

    writeback_stage_p #(.XLEN(32), .NUM_SRC(4), .RF_AW(5), .CNT_W(32)) dutA (
        .clk(clk), .rst_n(rst_n), .stall_i(stallA), .flush_i(flushA), .mIf(ifA),
        .result_w_o(resultA), .rd_w_o(rdA), .reg_write_w_o(regWriteA),
        .valid_w_o(validA), .retire_count_o(countA)
    );

    writeback_stage_p #(.XLEN(32), .NUM_SRC(3), .RF_AW(5), .CNT_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .stall_i(stallB), .flush_i(flushB), .mIf(ifB),
        .result_w_o(resultB), .rd_w_o(rdB), .reg_write_w_o(regWriteB),
        .valid_w_o(validB), .retire_count_o(countB)
    );

    int unsigned checkCount = 0;
    int unsigned failCount  = 0;

    task automatic checkVal(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  loadType;
        logic [1:0]  byteOff;
        logic [31:0] expected;
        string       tag;
    } loadVec_t;

    loadVec_t loadVecs[8];

    initial begin
        loadVecs[0] = '{3'b000, 2'd0, 32'hFFFFFF81, "lb_off0"};
        loadVecs[1] = '{3'b100, 2'd0, 32'h00000081, "lbu_off0"};
        loadVecs[2] = '{3'b000, 2'd1, 32'h0000007F, "lb_off1"};
        loadVecs[3] = '{3'b001, 2'd2, 32'hFFFF80F0, "lh_off2"};
        loadVecs[4] = '{3'b101, 2'd2, 32'h000080F0, "lhu_off2"};
        loadVecs[5] = '{3'b001, 2'd3, 32'hFFFF80F0, "lh_misaligned_off3"};
        loadVecs[6] = '{3'b011, 2'd1, 32'h80F07F81, "undef_funct3"};
        loadVecs[7] = '{3'b010, 2'd0, 32'h80F07F81, "lw"};

        rst_n  = 1'b0;
        stallA = 1'b0; flushA = 1'b0; stallB = 1'b0; flushB = 1'b0;
        ifA.valid_m_i = 1'b0; ifA.src_data_m_i = '0; ifA.result_src_m_i = '0;
        ifA.load_type_m_i = '0; ifA.byte_off_m_i = '0; ifA.reg_write_m_i = 1'b0;
        ifA.rd_m_i = '0;
        ifB.valid_m_i = 1'b0; ifB.src_data_m_i = '0; ifB.result_src_m_i = '0;
        ifB.load_type_m_i = '0; ifB.byte_off_m_i = '0; ifB.reg_write_m_i = 1'b0;
        ifB.rd_m_i = '0;

        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        stepCycle();

        checkVal("reset_result", 64'(resultA), 64'h0);
        checkVal("reset_rd", 64'(rdA), 64'h0);
        checkVal("reset_regwrite", 64'(regWriteA), 64'h0);
        checkVal("reset_valid", 64'(validA), 64'h0);
        checkVal("reset_count", 64'(countA), 64'h0);

        // ALU source
        ifA.valid_m_i = 1'b1;
        ifA.reg_write_m_i = 1'b1;
        ifA.rd_m_i = 5'd5;
        ifA.src_data_m_i[0 +: 32]  = 32'h12345678;
        ifA.src_data_m_i[32 +: 32] = 32'h80F07F81;
        ifA.src_data_m_i[64 +: 32] = 32'h00000104;
        ifA.src_data_m_i[96 +: 32] = 32'hCAFEF00D;
        ifA.result_src_m_i = 2'd0;
        stepCycle();
        checkVal("alu_result", 64'(resultA), 64'h12345678);
        checkVal("alu_regwrite", 64'(regWriteA), 64'h1);
        checkVal("alu_rd", 64'(rdA), 64'h5);
        checkVal("alu_valid", 64'(validA), 64'h1);
        checkVal("alu_count", 64'(countA), 64'h1);

        // PC+4 source
        ifA.result_src_m_i = 2'd2;
        stepCycle();
        checkVal("pc4_result", 64'(resultA), 64'h00000104);
        checkVal("pc4_count", 64'(countA), 64'h2);

        // Extra source
        ifA.result_src_m_i = 2'd3;
        stepCycle();
        checkVal("src3_result", 64'(resultA), 64'hCAFEF00D);

        // Load extraction
        ifA.result_src_m_i = 2'd1;
        foreach (loadVecs[i]) begin
            ifA.load_type_m_i = loadVecs[i].loadType;
            ifA.byte_off_m_i  = loadVecs[i].byteOff;
            stepCycle();
            checkVal(loadVecs[i].tag, 64'(resultA), 64'(loadVecs[i].expected));
        end
        checkVal("load_count", 64'(countA), 64'd11);

        // Stall with new M data: W holds, counter holds
        stallA = 1'b1;
        ifA.result_src_m_i = 2'd0;
        ifA.src_data_m_i[0 +: 32] = 32'hDEADBEEF;
        ifA.rd_m_i = 5'd7;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkVal("stall_result", 64'(resultA), 64'h80F07F81);
            checkVal("stall_rd", 64'(rdA), 64'h5);
            checkVal("stall_count", 64'(countA), 64'd11);
        end

        // Flush together with stall: bubble, no count
        flushA = 1'b1;
        stepCycle();
        checkVal("flush_valid", 64'(validA), 64'h0);
        checkVal("flush_regwrite", 64'(regWriteA), 64'h0);
        checkVal("flush_count", 64'(countA), 64'd11);
        flushA = 1'b0;
        stallA = 1'b0;

        // Write to x0 is suppressed but still retires
        ifA.rd_m_i = 5'd0;
        stepCycle();
        checkVal("x0_regwrite", 64'(regWriteA), 64'h0);
        checkVal("x0_valid", 64'(validA), 64'h1);
        checkVal("x0_result", 64'(resultA), 64'hDEADBEEF);
        checkVal("x0_count", 64'(countA), 64'd12);

        // Bubble: no count, no write
        ifA.valid_m_i = 1'b0;
        ifA.rd_m_i = 5'd9;
        stepCycle();
        checkVal("bubble_valid", 64'(validA), 64'h0);
        checkVal("bubble_regwrite", 64'(regWriteA), 64'h0);
        checkVal("bubble_count", 64'(countA), 64'd12);

        // Asynchronous reset mid-cycle with valid traffic
        ifA.valid_m_i = 1'b1;
        ifA.rd_m_i = 5'd3;
        stepCycle();
        checkVal("prereset_count", 64'(countA), 64'd13);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("areset_result", 64'(resultA), 64'h0);
        checkVal("areset_rd", 64'(rdA), 64'h0);
        checkVal("areset_regwrite", 64'(regWriteA), 64'h0);
        checkVal("areset_valid", 64'(validA), 64'h0);
        checkVal("areset_count", 64'(countA), 64'h0);
        stepCycle();
        ifA.valid_m_i = 1'b0;
        rst_n = 1'b1;
        stepCycle();

        // NUM_SRC=3 build: select 3 is out of range
        ifB.valid_m_i = 1'b1;
        ifB.reg_write_m_i = 1'b1;
        ifB.rd_m_i = 5'd4;
        ifB.src_data_m_i = {32'h00000104, 32'h80F07F81, 32'h12345678};
        ifB.result_src_m_i = 2'd3;
        stepCycle();
        checkVal("b_sel_oob_result", 64'(resultB), 64'h0);
        checkVal("b_sel_oob_count", 64'(countB), 64'h1);

        ifB.result_src_m_i = 2'd2;
        stepCycle();
        checkVal("b_sel2_result", 64'(resultB), 64'h00000104);

        // 15 more valid captures interleaved with bubbles: 17 total -> wraps to 1
        for (int i = 0; i < 30; i++) begin
            ifB.valid_m_i = (i % 2 == 0);
            stepCycle();
        end
        ifB.valid_m_i = 1'b0;
        stepCycle();
        checkVal("b_wrap_count", 64'(countB), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/writeback_stage_p.md
Name: writeback_stage_p

Overview:
- Parametrised writeback stage for the pipelined RISC-V core.
- Holds the MEM/WB pipeline register with stall and flush control.
- Selects the result from NUM_SRC sources and aligns, sign-extends or zero-extends load data.
- Gates the register-file write and keeps a retired-instruction counter.
- Sits between the memory stage and the register file; its outputs also drive the hazard unit's W-stage forwarding path.

Parameters:
- XLEN, 32: datapath width, must be ≥32 and a multiple of 8.
- NUM_SRC, 4: number of result sources, must be ≥3. Index 0 = ALU, 1 = load data, 2 = PC+4, 3+ = extra (imm/CSR).
- SRC_W, $clog2(NUM_SRC): width of the result select.
- RF_AW, 5: register-file address width.
- CNT_W, 32: retire counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold W register contents
- flush_i  in  1  insert bubble into W
- valid_m_i  in  1  M-stage instruction valid
- src_data_m_i  in  NUM_SRC*XLEN  packed sources; source k occupies bits [k*XLEN +: XLEN]
- result_src_m_i  in  SRC_W  source select
- load_type_m_i  in  3  RISC-V funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- byte_off_m_i  in  2  address bits [1:0] of the load
- reg_write_m_i  in  1  instruction writes rd
- rd_m_i  in  RF_AW  destination register
- result_w_o  out  XLEN  final writeback value
- rd_w_o  out  RF_AW  destination to register file
- reg_write_w_o  out  1  qualified register-file write enable
- valid_w_o  out  1  W holds a valid instruction
- retire_count_o  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst_n=0, asynchronous): all W registers clear. valid_w_o=0, reg_write_w_o=0, rd_w_o=0, result_w_o=0, retire_count_o=0.
- Register update priority, evaluated at each posedge:
  - flush_i=1: valid_w←0, reg_write_w←0; data fields don't-care. Flush wins over stall.
  - else stall_i=1: all W registers hold.
  - else: capture valid_m_i, all sources, result_src, load_type, byte_off, reg_write, rd.
- Latency: one cycle from M inputs to W outputs. Result selection and load extraction are combinational from the W registers; no extra cycle.
- Result select:
  - result_w_o = registered source[result_src]; source 1 passes through load extraction first.
  - result_src ≥ NUM_SRC yields 0.
- Load extraction on source 1, with lane = byte_off:
  - LB/LBU select byte lane; LH/LHU select halfword (byte_off[1]); LW passes through unchanged.
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - Misaligned halfword (byte_off[0]=1) uses byte_off[1] only; misalignment is trapped upstream.
  - Undefined funct3 passes the word through unchanged.
  - When XLEN>32, LW sign-extends bits [31:0].
- Write enable: reg_write_w_o = valid_w & reg_write_w & (rd_w≠0). x0 is never written.
- During stall the same write is re-presented each cycle; this is idempotent and acceptable.
- Retire counter:
  - Increments by 1 on each posedge where a capture occurs (no flush, no stall) with valid_m_i=1.
  - Wraps modulo 2^CNT_W with no saturation and no flag.
  - Reset mid-operation clears the counter immediately and asynchronously.
- Simultaneous flush and stall: flush applies and the counter does not increment.
- Outputs are glitch-free registered values except result_w_o, which is combinational from registered values only. There is no combinational path from M inputs to any output.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with valid traffic → all outputs 0 immediately, before the next clock edge; retire_count_o=0.
- ALU/PC+4 path: valid=1, src0=0x12345678, sel=0, rd=5, reg_write=1 → next cycle result_w_o=0x12345678, reg_write_w_o=1, rd_w_o=5. Then sel=2, src2=0x00000104 → 0x00000104.
- Load extraction: src1=0x80F07F81.
  - LB, off=0 → 0xFFFFFF81
  - LBU, off=0 → 0x00000081
  - LB, off=1 → 0x0000007F
  - LH, off=2 → 0xFFFF80F0
  - LHU, off=2 → 0x000080F0
  - LW → 0x80F07F81
- Stall/flush:
  - Stall 3 cycles with new M data → W outputs unchanged and counter unchanged.
  - flush+stall together → valid_w_o=0, reg_write_w_o=0.
- x0 and invalid select: rd=0, reg_write=1 → reg_write_w_o=0. sel=NUM_SRC (non-power-of-2 build, NUM_SRC=3, sel=3) → result_w_o=0.
- Counter wrap: CNT_W=4, 17 valid captures → retire_count_o=1. Bubbles (valid_m_i=0) do not increment.
